multi_cycle_ctrl: RTL and testbench

- Parametrised multi-cycle control unit; successor to the single-cycle control block.
- Sequences each MIPS-subset instruction through IF/ID/EX/MEM/WB states, so one ALU and one unified memory are shared across cycles.
- Supports memory wait states and an optional interrupt entry/return path.
- Sits between the instruction register (opcode/func) and the multi-cycle datapath plus unified memory.

---
 rtl/multi_cycle_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: sequences IF/ID/EX/MRD/MWR/WB over a shared ALU and memory.
// Define INT_EN to enable the interrupt entry state and the eret return path.
module multi_cycle_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       INT,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] Mem2Reg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       EPCWrite,
  output logic       VecSel,
  output logic       IntAck,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_EX  = 4'd2,
    S_MRD = 4'd3,
    S_MWR = 4'd4,
    S_WB  = 4'd5,
    S_INT = 4'd6
  } state_t;

  typedef enum logic [3:0] {
    K_ILL  = 4'd0,
    K_R    = 4'd1,
    K_JR   = 4'd2,
    K_IMM  = 4'd3,
    K_LW   = 4'd4,
    K_SW   = 4'd5,
    K_BEQ  = 4'd6,
    K_BNE  = 4'd7,
    K_J    = 4'd8,
    K_JAL  = 4'd9,
    K_ERET = 4'd10
  } kind_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  kind_t            kind_s;
  logic [2:0]       alu_op_s;
  logic             mem_done_s;
  logic             int_take_s;
  state_t           if_target_s;

  logic       pc_wr_s, ir_wr_s, iord_s, mem_rd_s, mem_wr_s, reg_wr_s;
  logic [1:0] reg_dst_s, mem2reg_s, src_b_s, pc_src_s;
  logic       src_a_s, epc_wr_s, vec_sel_s, int_ack_s, illegal_s;
  logic [2:0] alu_ctl_s;

`ifdef INT_EN
  logic ie_q, ie_d;
  assign int_take_s = INT & ie_q;
`else
  logic int_unused_s;
  assign int_unused_s = INT;
  assign int_take_s   = 1'b0;
`endif

  assign mem_done_s  = (cnt_q == CNT_LAST);
  assign if_target_s = int_take_s ? S_INT : S_IF;

  // Instruction class and ALU operation decoded from opcode/func.
  always_comb begin
    kind_s   = K_ILL;
    alu_op_s = 3'b010;
    case (opcode)
      6'b000000: begin
        case (func)
          6'b100000: begin kind_s = K_R; alu_op_s = 3'b010; end
          6'b100010: begin kind_s = K_R; alu_op_s = 3'b110; end
          6'b100100: begin kind_s = K_R; alu_op_s = 3'b000; end
          6'b100101: begin kind_s = K_R; alu_op_s = 3'b001; end
          6'b100111: begin kind_s = K_R; alu_op_s = 3'b100; end
          6'b101010: begin kind_s = K_R; alu_op_s = 3'b111; end
          6'b001000: kind_s = K_JR;
          default:   kind_s = K_ILL;
        endcase
      end
      6'b000010: kind_s = K_J;
      6'b000011: kind_s = K_JAL;
      6'b000100: kind_s = K_BEQ;
      6'b000101: kind_s = K_BNE;
      6'b001000: begin kind_s = K_IMM; alu_op_s = 3'b010; end
      6'b001010: begin kind_s = K_IMM; alu_op_s = 3'b111; end
      6'b001100: begin kind_s = K_IMM; alu_op_s = 3'b000; end
      // ori needs the zero-extended form; lui has its own ALU op
      6'b001101: begin kind_s = K_IMM; alu_op_s = 3'b101; end
      6'b001111: begin kind_s = K_IMM; alu_op_s = 3'b011; end
      6'b100011: kind_s = K_LW;
      6'b101011: kind_s = K_SW;
`ifdef INT_EN
      6'b010000: begin
        if (func == 6'b011000) begin
          kind_s = K_ERET;
        end else begin
          kind_s = K_ILL;
        end
      end
`endif
      default: kind_s = K_ILL;
    endcase
  end

  // Next state, wait-state counter and interrupt-enable update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef INT_EN
    ie_d    = ie_q;
`endif
    case (state_q)
      S_IF: begin
        if (mem_done_s) begin
          state_d = S_ID;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ID: begin
        case (kind_s)
          K_R, K_IMM, K_LW, K_SW, K_BEQ, K_BNE: state_d = S_EX;
`ifdef INT_EN
          K_ERET: begin
            ie_d    = 1'b1;
            state_d = if_target_s;
          end
`endif
          default: state_d = if_target_s;
        endcase
      end
      S_EX: begin
        case (kind_s)
          K_LW:       state_d = S_MRD;
          K_SW:       state_d = S_MWR;
          K_R, K_IMM: state_d = S_WB;
          default:    state_d = if_target_s;
        endcase
      end
      S_MRD: begin
        if (mem_done_s) begin
          state_d = S_WB;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_MWR: begin
        if (mem_done_s) begin
          state_d = if_target_s;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WB: state_d = if_target_s;
      S_INT: begin
`ifdef INT_EN
        ie_d = 1'b0;
`endif
        state_d = S_IF;
      end
      default: begin
        state_d = S_IF;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and interrupt-enable registers with synchronous reset.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q <= S_IF;
      cnt_q   <= {CNT_W{1'b0}};
`ifdef INT_EN
      ie_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef INT_EN
      ie_q    <= ie_d;
`endif
    end
  end

  // Datapath control decode from state, counter, instruction class and zero flag.
  always_comb begin
    pc_wr_s   = 1'b0;
    ir_wr_s   = 1'b0;
    iord_s    = 1'b0;
    mem_rd_s  = 1'b0;
    mem_wr_s  = 1'b0;
    reg_wr_s  = 1'b0;
    reg_dst_s = 2'b00;
    mem2reg_s = 2'b00;
    src_a_s   = 1'b0;
    src_b_s   = 2'b00;
    alu_ctl_s = 3'b010;
    pc_src_s  = 2'b00;
    epc_wr_s  = 1'b0;
    vec_sel_s = 1'b0;
    int_ack_s = 1'b0;
    illegal_s = 1'b0;
    case (state_q)
      S_IF: begin
        mem_rd_s = 1'b1;
        src_b_s  = 2'b01;
        if (mem_done_s) begin
          ir_wr_s = 1'b1;
          pc_wr_s = 1'b1;
        end else begin
          ir_wr_s = 1'b0;
        end
      end
      S_ID: begin
        src_b_s = 2'b11;
        case (kind_s)
          K_J: begin
            pc_wr_s  = 1'b1;
            pc_src_s = 2'b10;
          end
          K_JAL: begin
            pc_wr_s   = 1'b1;
            pc_src_s  = 2'b10;
            reg_wr_s  = 1'b1;
            reg_dst_s = 2'b10;
            mem2reg_s = 2'b10;
          end
          K_JR: begin
            pc_wr_s  = 1'b1;
            pc_src_s = 2'b11;
          end
          K_ERET: begin
            pc_wr_s  = 1'b1;
            pc_src_s = 2'b01;
          end
          K_ILL:   illegal_s = 1'b1;
          default: illegal_s = 1'b0;
        endcase
      end
      S_EX: begin
        src_a_s = 1'b1;
        case (kind_s)
          K_R: alu_ctl_s = alu_op_s;
          K_IMM: begin
            src_b_s   = 2'b10;
            alu_ctl_s = alu_op_s;
          end
          K_LW, K_SW: src_b_s = 2'b10;
          K_BEQ: begin
            alu_ctl_s = 3'b110;
            pc_src_s  = 2'b01;
            pc_wr_s   = zero;
          end
          K_BNE: begin
            alu_ctl_s = 3'b110;
            pc_src_s  = 2'b01;
            pc_wr_s   = ~zero;
          end
          default: alu_ctl_s = 3'b010;
        endcase
      end
      S_MRD: begin
        mem_rd_s = 1'b1;
        iord_s   = 1'b1;
      end
      S_MWR: begin
        mem_wr_s = 1'b1;
        iord_s   = 1'b1;
      end
      S_WB: begin
        reg_wr_s = 1'b1;
        case (kind_s)
          K_LW:    mem2reg_s = 2'b01;
          K_R:     reg_dst_s = 2'b01;
          default: reg_dst_s = 2'b00;
        endcase
      end
`ifdef INT_EN
      S_INT: begin
        epc_wr_s  = 1'b1;
        pc_wr_s   = 1'b1;
        vec_sel_s = 1'b1;
        int_ack_s = 1'b1;
      end
`endif
      default: pc_wr_s = 1'b0;
    endcase
  end

  // Enables and strobes are suppressed for the whole time reset is high.
  assign PCWrite    = pc_wr_s   & ~reset;
  assign IRWrite    = ir_wr_s   & ~reset;
  assign MemRead    = mem_rd_s  & ~reset;
  assign MemWrite   = mem_wr_s  & ~reset;
  assign RegWrite   = reg_wr_s  & ~reset;
  assign EPCWrite   = epc_wr_s  & ~reset;
  assign IntAck     = int_ack_s & ~reset;
  assign Illegal    = illegal_s & ~reset;
  assign VecSel     = vec_sel_s;
  assign IorD       = iord_s;
  assign RegDst     = reg_dst_s;
  assign Mem2Reg    = mem2reg_s;
  assign ALUSrcA    = src_a_s;
  assign ALUSrcB    = src_b_s;
  assign ALUControl = alu_ctl_s;
  assign PCSrc      = pc_src_s;
  assign State      = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: two instances (MEM_LAT = 2 and 0), table-driven instruction runs
// checked through a scoreboard, plus hand sequences for reset mid-access and the interrupt path.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic       pcw, irw, iord, mr, mw, rw;
    logic [1:0] rd, m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
    logic       epcw, vec, ack, ill;
    logic [3:0] st;
  } obs_t;

  typedef struct {
    logic       l0;
    logic [5:0] op, fn;
    logic       z, intr;
    int         cyc, mr, mw, pcw, rw, rw_at, rd, m2r, irw_at, ill, aluc, pcs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_l2, rst_l0, sel_l0;
  logic [5:0] opcode, func;
  logic       zero, int_req;

  logic       l2_pcw, l2_irw, l2_iord, l2_mr, l2_mw, l2_rw, l2_srca, l2_epcw, l2_vec, l2_ack, l2_ill;
  logic [1:0] l2_rd, l2_m2r, l2_srcb, l2_pcsrc;
  logic [2:0] l2_aluc;
  logic [3:0] l2_st;
  logic       l0_pcw, l0_irw, l0_iord, l0_mr, l0_mw, l0_rw, l0_srca, l0_epcw, l0_vec, l0_ack, l0_ill;
  logic [1:0] l0_rd, l0_m2r, l0_srcb, l0_pcsrc;
  logic [2:0] l0_aluc;
  logic [3:0] l0_st;
  obs_t       obs;

  multi_cycle_ctrl #(.MEM_LAT(2), .CNT_W(4)) u_l2 (
    .clk_cpu(clk), .reset(rst_l2), .opcode(opcode), .func(func), .zero(zero), .INT(int_req),
    .PCWrite(l2_pcw), .IRWrite(l2_irw), .IorD(l2_iord), .MemRead(l2_mr), .MemWrite(l2_mw),
    .RegWrite(l2_rw), .RegDst(l2_rd), .Mem2Reg(l2_m2r), .ALUSrcA(l2_srca), .ALUSrcB(l2_srcb),
    .ALUControl(l2_aluc), .PCSrc(l2_pcsrc), .EPCWrite(l2_epcw), .VecSel(l2_vec), .IntAck(l2_ack),
    .Illegal(l2_ill), .State(l2_st)
  );

  multi_cycle_ctrl #(.MEM_LAT(0), .CNT_W(4)) u_l0 (
    .clk_cpu(clk), .reset(rst_l0), .opcode(opcode), .func(func), .zero(zero), .INT(int_req),
    .PCWrite(l0_pcw), .IRWrite(l0_irw), .IorD(l0_iord), .MemRead(l0_mr), .MemWrite(l0_mw),
    .RegWrite(l0_rw), .RegDst(l0_rd), .Mem2Reg(l0_m2r), .ALUSrcA(l0_srca), .ALUSrcB(l0_srcb),
    .ALUControl(l0_aluc), .PCSrc(l0_pcsrc), .EPCWrite(l0_epcw), .VecSel(l0_vec), .IntAck(l0_ack),
    .Illegal(l0_ill), .State(l0_st)
  );

  assign obs = sel_l0 ?
    {l0_pcw, l0_irw, l0_iord, l0_mr, l0_mw, l0_rw, l0_rd, l0_m2r, l0_srca, l0_srcb, l0_aluc,
     l0_pcsrc, l0_epcw, l0_vec, l0_ack, l0_ill, l0_st} :
    {l2_pcw, l2_irw, l2_iord, l2_mr, l2_mw, l2_rw, l2_rd, l2_m2r, l2_srca, l2_srcb, l2_aluc,
     l2_pcsrc, l2_epcw, l2_vec, l2_ack, l2_ill, l2_st};

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t sb_q[$];
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int enables();
    return int'({obs.pcw, obs.irw, obs.mr, obs.mw, obs.rw, obs.epcw, obs.vec, obs.ack, obs.ill});
  endfunction

  function automatic vec_t mk(input logic l0, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic intr, input int cyc, input int mr,
                              input int mw, input int pcw, input int rw, input int rw_at,
                              input int rd, input int m2r, input int ill, input int aluc,
                              input int pcs);
    vec_t v;
    v.l0 = l0; v.op = op; v.fn = fn; v.z = z; v.intr = intr;
    v.cyc = cyc; v.mr = mr; v.mw = mw; v.pcw = pcw; v.rw = rw; v.rw_at = rw_at;
    v.rd = rd; v.m2r = m2r; v.ill = ill; v.aluc = aluc; v.pcs = pcs;
    v.irw_at = l0 ? 1 : 3;   // last IF cycle is MEM_LAT+1
    return v;
  endfunction

  // Runs one instruction from IF cycle 1 until the next IF entry, then checks the scoreboard entry.
  task automatic run_instr(input vec_t v, input string tag);
    vec_t e;
    int cyc = 0, mr = 0, mw = 0, pcw = 0, rw = 0, rw_at = 0, rd = 0, m2r = 0;
    int irw_at = 0, irw_n = 0, ill = 0, aluc = -1, pcs = -1;
    logic [3:0] prev = 4'd0;
    bit done = 1'b0;
    sb_q.push_back(v);
    opcode = v.op; func = v.fn; zero = v.z; int_req = v.intr;
    #1;
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
        if (obs.st == 4'd0 && prev != 4'd0) done = 1'b1;
      end
      if (!done) begin
        cyc++;
        mr += int'(obs.mr); mw += int'(obs.mw); pcw += int'(obs.pcw); ill += int'(obs.ill);
        irw_n += int'(obs.irw);
        if (obs.irw && irw_at == 0) irw_at = cyc;
        if (obs.rw) begin rw++; rw_at = cyc; rd = int'(obs.rd); m2r = int'(obs.m2r); end
        if (obs.st == 4'd2) aluc = int'(obs.aluc);
        if (obs.pcw && obs.st != 4'd0) pcs = int'(obs.pcsrc);
        prev = obs.st;
      end
    end
    e = sb_q.pop_front();
    if (!done) begin
      n_chk++;
      $display("FAIL %s timeout: no return to IF within 40 cycles", tag);
    end
    chk({tag, " cycles"}, cyc, e.cyc);
    chk({tag, " MemRead cycles"}, mr, e.mr);
    chk({tag, " MemWrite cycles"}, mw, e.mw);
    chk({tag, " PCWrite cycles"}, pcw, e.pcw);
    chk({tag, " RegWrite cycles"}, rw, e.rw);
    chk({tag, " RegWrite cycle"}, rw_at, e.rw_at);
    chk({tag, " RegDst"}, rd, e.rd);
    chk({tag, " Mem2Reg"}, m2r, e.m2r);
    chk({tag, " IRWrite cycle"}, irw_at, e.irw_at);
    chk({tag, " IRWrite count"}, irw_n, 1);
    chk({tag, " Illegal pulses"}, ill, e.ill);
    chk({tag, " EX ALUControl"}, aluc, e.aluc);
    chk({tag, " PCSrc on jump/branch"}, pcs, e.pcs);
  endtask

  // Holds both instances in reset for two edges, then releases the selected one.
  task automatic do_reset(input logic to_l0);
    sel_l0 = to_l0; rst_l2 = 1'b1; rst_l0 = 1'b1;
    opcode = 6'd0; func = 6'd0; zero = 1'b0; int_req = 1'b0;
    #1;
    chk("reset enables c1", enables(), 0);
    @(negedge clk); #1;
    chk("reset enables c2", enables(), 0);
    @(negedge clk);
    if (to_l0) rst_l0 = 1'b0; else rst_l2 = 1'b0;
    #1;
    chk("release State", int'(obs.st), 0);
    chk("release MemRead", int'(obs.mr), 1);
    chk("release ALUSrcB", int'(obs.srcb), 1);
    chk("release ALUSrcA", int'(obs.srca), 0);
  endtask

`ifdef INT_EN
  // An add with INT high: after WB the unit must spend one cycle in INT, then return to IF.
  task automatic int_entry(input string tag);
    bit found = 1'b0;
    opcode = 6'b000000; func = 6'b100000; zero = 1'b0; int_req = 1'b1;
    #1;
    for (int k = 0; k < 20 && !found; k++) begin
      if (obs.st == 4'd5) found = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk({tag, " WB reached"}, int'(found), 1);
    @(negedge clk); #1;
    chk({tag, " State INT"}, int'(obs.st), 6);
    chk({tag, " EPCWrite/VecSel/IntAck/PCWrite"}, int'({obs.epcw, obs.vec, obs.ack, obs.pcw}), 15);
    @(negedge clk); #1;
    chk({tag, " back to IF"}, int'(obs.st), 0);
    chk({tag, " INT strobes drop"}, int'({obs.epcw, obs.vec, obs.ack}), 0);
  endtask
`endif

  initial begin
    bit found;
    // MEM_LAT = 2 rows
    tbl.push_back(mk(0, 6'b000000, 6'b100000, 0, 0, 6, 3, 0, 1, 1, 6, 1, 0, 0, 2, -1));
    tbl.push_back(mk(0, 6'b000000, 6'b100010, 0, 0, 6, 3, 0, 1, 1, 6, 1, 0, 0, 6, -1));
    tbl.push_back(mk(0, 6'b000000, 6'b100100, 0, 0, 6, 3, 0, 1, 1, 6, 1, 0, 0, 0, -1));
    tbl.push_back(mk(0, 6'b000000, 6'b100101, 0, 0, 6, 3, 0, 1, 1, 6, 1, 0, 0, 1, -1));
    tbl.push_back(mk(0, 6'b000000, 6'b100111, 0, 0, 6, 3, 0, 1, 1, 6, 1, 0, 0, 4, -1));
    tbl.push_back(mk(0, 6'b000000, 6'b101010, 0, 0, 6, 3, 0, 1, 1, 6, 1, 0, 0, 7, -1));
    tbl.push_back(mk(0, 6'b001000, 6'b000000, 0, 0, 6, 3, 0, 1, 1, 6, 0, 0, 0, 2, -1));
    tbl.push_back(mk(0, 6'b001010, 6'b000000, 0, 0, 6, 3, 0, 1, 1, 6, 0, 0, 0, 7, -1));
    tbl.push_back(mk(0, 6'b001100, 6'b000000, 0, 0, 6, 3, 0, 1, 1, 6, 0, 0, 0, 0, -1));
    tbl.push_back(mk(0, 6'b001101, 6'b000000, 0, 0, 6, 3, 0, 1, 1, 6, 0, 0, 0, 5, -1));
    tbl.push_back(mk(0, 6'b001111, 6'b000000, 0, 0, 6, 3, 0, 1, 1, 6, 0, 0, 0, 3, -1));
    tbl.push_back(mk(0, 6'b100011, 6'b000000, 0, 0, 9, 6, 0, 1, 1, 9, 0, 1, 0, 2, -1));
    tbl.push_back(mk(0, 6'b101011, 6'b000000, 0, 0, 8, 3, 3, 1, 0, 0, 0, 0, 0, 2, -1));
    tbl.push_back(mk(0, 6'b000100, 6'b000000, 1, 0, 5, 3, 0, 2, 0, 0, 0, 0, 0, 6, 1));
    tbl.push_back(mk(0, 6'b000100, 6'b000000, 0, 0, 5, 3, 0, 1, 0, 0, 0, 0, 0, 6, -1));
    tbl.push_back(mk(0, 6'b000101, 6'b000000, 0, 0, 5, 3, 0, 2, 0, 0, 0, 0, 0, 6, 1));
    tbl.push_back(mk(0, 6'b000101, 6'b000000, 1, 0, 5, 3, 0, 1, 0, 0, 0, 0, 0, 6, -1));
    tbl.push_back(mk(0, 6'b000010, 6'b000000, 0, 0, 4, 3, 0, 2, 0, 0, 0, 0, 0, -1, 2));
    tbl.push_back(mk(0, 6'b000011, 6'b000000, 0, 0, 4, 3, 0, 2, 1, 4, 2, 2, 0, -1, 2));
    tbl.push_back(mk(0, 6'b000000, 6'b001000, 0, 0, 4, 3, 0, 2, 0, 0, 0, 0, 0, -1, 3));
    tbl.push_back(mk(0, 6'b111111, 6'b000000, 0, 0, 4, 3, 0, 1, 0, 0, 0, 0, 1, -1, -1));
    tbl.push_back(mk(0, 6'b000000, 6'b000000, 0, 0, 4, 3, 0, 1, 0, 0, 0, 0, 1, -1, -1));
`ifndef INT_EN
    tbl.push_back(mk(0, 6'b000000, 6'b100000, 0, 1, 6, 3, 0, 1, 1, 6, 1, 0, 0, 2, -1));
    tbl.push_back(mk(1, 6'b010000, 6'b011000, 0, 1, 2, 1, 0, 1, 0, 0, 0, 0, 1, -1, -1));
`endif
    // MEM_LAT = 0 rows
    tbl.push_back(mk(1, 6'b100011, 6'b000000, 0, 0, 5, 2, 0, 1, 1, 5, 0, 1, 0, 2, -1));
    tbl.push_back(mk(1, 6'b101011, 6'b000000, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 0, 2, -1));
    tbl.push_back(mk(1, 6'b000000, 6'b100000, 0, 0, 4, 1, 0, 1, 1, 4, 1, 0, 0, 2, -1));
    tbl.push_back(mk(1, 6'b000100, 6'b000000, 1, 0, 3, 1, 0, 2, 0, 0, 0, 0, 0, 6, 1));

    do_reset(1'b0);
    foreach (tbl[i]) if (!tbl[i].l0) run_instr(tbl[i], $sformatf("L2 row%0d", i));

    // sw interrupted by reset while in MWR: the write must be dropped and IF restart cleanly
    opcode = 6'b101011; func = 6'b000000; zero = 1'b0; int_req = 1'b0;
    #1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (obs.st == 4'd4) found = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk("midrst MWR reached", int'(found), 1);
    chk("midrst MemWrite/IorD before", int'({obs.mw, obs.iord}), 3);
    rst_l2 = 1'b1;
    #1;
    chk("midrst enables in reset", enables(), 0);
    @(negedge clk); #1;
    chk("midrst State after edge", int'(obs.st), 0);
    chk("midrst enables held", enables(), 0);
    rst_l2 = 1'b0;
    #1;
    chk("midrst MemRead restart", int'(obs.mr), 1);
    run_instr(tbl[0], "midrst add");

`ifdef INT_EN
    int_entry("int1");
    run_instr(mk(0, 6'b000000, 6'b100000, 0, 1, 6, 3, 0, 1, 1, 6, 1, 0, 0, 2, -1), "int masked add");
    run_instr(mk(0, 6'b010000, 6'b011000, 0, 1, 4, 3, 0, 2, 0, 0, 0, 0, 0, -1, 1), "eret");
    int_entry("int2");
    int_req = 1'b0;
`endif

    do_reset(1'b1);
    foreach (tbl[i]) if (tbl[i].l0) run_instr(tbl[i], $sformatf("L0 row%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
